video_timing_480p: RTL and testbench
====================================

// Module: video_timing_480p
// PURPOSE
// - Consumer end of the 480p pixel-clock interface: runs on PCLK (25.2 MHz), qualifies PLOCK, then
//   generates 640x480@60 raster timing (HSYNC, VSYNC, DE, X/Y, frame/line strobes) for the video output path.
// - Holds all outputs idle until the PLL has been locked for LOCK_WAIT cycles. Drops back to idle on loss of lock.
// PARAMETERS
// - H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing in pixels (H_TOTAL=800)
// - V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing in lines (V_TOTAL=525)
// - SYNC_POL 0     : sync active level (0 = active-low, idle high)
// - LOCK_WAIT 1024 : consecutive synchronized-PLOCK-high cycles required before RUN (>=1)
// - CNT_W 10       : width of X/Y and internal h/v counters (must hold H_TOTAL-1, V_TOTAL-1)
// PORTS
// - PCLK        in   1      pixel clock; the only clock
// - RESET_n     in   1      reset, synchronous, active-low
// - PLOCK       in   1      PLL lock; asynchronous to PCLK; passed through a 2-flop synchronizer
// - HSYNC       out  1      horizontal sync, level per SYNC_POL
// - VSYNC       out  1      vertical sync, level per SYNC_POL
// - DE          out  1      active-video enable
// - X           out  CNT_W  horizontal position (0..H_TOTAL-1); meaningful when DE=1
// - Y           out  CNT_W  vertical position (0..V_TOTAL-1)
// - LINE_START  out  1      1-cycle pulse when X=0, every line including blanking lines
// - FRAME_START out  1      1-cycle pulse when X=0 and Y=0
// - RUN         out  1      high while raster is generating
// BEHAVIOUR
// - Reset (RESET_n=0 at PCLK edge): state WAIT_LOCK, counters 0, HSYNC=VSYNC=~SYNC_POL, DE=0, X=Y=0,
//   LINE_START=FRAME_START=0, RUN=0, synchronizer flops 0. Same idle values in WAIT_LOCK and SETTLE.
// - lock_s = PLOCK after 2 PCLK flops (2-cycle latency).
// - FSM: WAIT_LOCK --lock_s=1--> SETTLE (settle cnt cleared to 0).
//   SETTLE: cnt++ each cycle with lock_s=1. When cnt reaches LOCK_WAIT-1 -> RUN. lock_s=0 -> WAIT_LOCK.
//   RUN: lock_s=0 -> WAIT_LOCK; counters cleared, outputs idle the following cycle.
//   A loss of lock mid-frame abandons the frame; a later RUN always restarts at h=v=0.
// - Counters (RUN only): h=0 on RUN entry, h++ each cycle, h wraps H_TOTAL-1->0. On wrap, v++ and v wraps V_TOTAL-1->0.
// - Outputs are registered decodes of (h,v), giving 1-cycle latency: DE/X/Y/FRAME_START for (0,0) appear the
//   cycle after the RUN entry cycle. RUN rises in that same cycle.
// - DE = (h<H_ACTIVE)&&(v<V_ACTIVE). X=h, Y=v always, including blanking.
// - HSYNC active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
// - VSYNC active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], for whole lines (changes at h=0).
// - Invariants: exactly H_ACTIVE*V_ACTIVE = 307200 DE cycles per frame. Frame period = 420000 cycles.
// - Simultaneous events: RESET_n=0 overrides everything. lock_s=0 overrides counter advance.
//   h wrap with v wrap gives h=v=0 (next FRAME_START).
// - Counter arithmetic is unsigned CNT_W bits. Wrap uses compare to TOTAL-1, never overflow.
// STRUCTURE
// - Package video_timing_pkg: derived localparams H_TOTAL, V_TOTAL, HS_START/HS_END, VS_START/VS_END;
//   typedef enum {WAIT_LOCK, SETTLE, RUN} vt_state_t.
// - Sub-module lock_qualifier: 2-flop PLOCK synchronizer plus settle counter plus FSM. Output: run_en.
// - Top: h/v counters plus registered decode. No other sub-modules.
// TESTING (use LOCK_WAIT=16 for speed unless noted)
// - Lock-up: reset, then PLOCK=1 at cycle 0 -> RUN=0 through cycle 2+16. DE=1, X=0, Y=0, FRAME_START=1 one cycle after RUN entry.
// - Line timing: in RUN, DE high 640 cycles per line. HSYNC low exactly 96 cycles, X=656..751. LINE_START period 800 cycles.
// - Frame timing: VSYNC low for 2 lines at Y=490,491 (1600 cycles). FRAME_START period 420000.
//   DE count per frame = 307200. Y never exceeds 524.
// - Lock glitch in SETTLE: PLOCK low 3 cycles at settle count 10 -> back to WAIT_LOCK. Full 16-cycle settle required again.
// - Lock loss mid-frame (Y=200): within 3 cycles DE=0, HSYNC=VSYNC=1, RUN=0.
//   After relock plus settle, raster restarts at X=0, Y=0 with FRAME_START.
// - Reset mid-frame with PLOCK held high: RESET_n=0 one cycle at Y=300 -> next cycle outputs idle, state WAIT_LOCK.
//   RUN returns after 2+16 cycles, starting at (0,0).

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing defaults, derived raster constants and the lock FSM state type.
package video_timing_pkg;

   localparam int unsigned H_ACTIVE_DEF  = 640;
   localparam int unsigned H_FP_DEF      = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BP_DEF      = 48;
   localparam int unsigned V_ACTIVE_DEF  = 480;
   localparam int unsigned V_FP_DEF      = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BP_DEF      = 33;
   localparam int unsigned LOCK_WAIT_DEF = 1024;
   localparam int unsigned CNT_W_DEF     = 10;

   localparam int unsigned H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int unsigned HS_START = H_ACTIVE_DEF + H_FP_DEF;
   localparam int unsigned HS_END   = HS_START + H_SYNC_DEF - 1;
   localparam int unsigned VS_START = V_ACTIVE_DEF + V_FP_DEF;
   localparam int unsigned VS_END   = VS_START + V_SYNC_DEF - 1;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } vt_state_t;

   // Inclusive window test; counters are zero-extended to 16 bits by the caller.
   function automatic logic in_window(input logic [15:0] val,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/video_timing_480p_lock_qualifier.sv
// PLOCK synchronizer and settle qualifier: run_en is high only while the PLL has been
// continuously locked for LOCK_WAIT cycles and is still locked.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_LOCK | synchronized lock low; settle count held at 0
//   SETTLE    | lock high; counting up to LOCK_WAIT-1 consecutive cycles
//   RUN       | lock qualified; raster runs while lock stays high
module lock_qualifier
   import video_timing_pkg::*;
#(
   parameter int unsigned LOCK_WAIT = LOCK_WAIT_DEF
) (
   input  logic PCLK,
   input  logic RESET_n,
   input  logic PLOCK,
   output logic run_en
);

   localparam int unsigned SET_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_WAIT - 1);

   logic [1:0]       sync_q;
   logic             lock_s;
   vt_state_t        state_q, state_d;
   logic [SET_W-1:0] cnt_q, cnt_d;

   assign lock_s = sync_q[1];

   always_ff @(posedge PCLK) begin
      if (!RESET_n) begin
         sync_q  <= 2'b00;
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], PLOCK};
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (lock_s) state_d = SETTLE;
         end
         SETTLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == SET_LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) state_d = WAIT_LOCK;
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // Gating with lock_s lets a lock drop stop the counters in the same cycle it is seen.
   assign run_en = (state_q == RUN) && lock_s;

endmodule

// File: rtl/video_timing_480p.sv
// 640x480@60 raster generator on PCLK: h/v counters with a registered decode of sync,
// active-video, position and start strobes, held idle until the PLL lock is qualified.
module video_timing_480p #(
   parameter int unsigned H_ACTIVE  = video_timing_pkg::H_ACTIVE_DEF,
   parameter int unsigned H_FP      = video_timing_pkg::H_FP_DEF,
   parameter int unsigned H_SYNC    = video_timing_pkg::H_SYNC_DEF,
   parameter int unsigned H_BP      = video_timing_pkg::H_BP_DEF,
   parameter int unsigned V_ACTIVE  = video_timing_pkg::V_ACTIVE_DEF,
   parameter int unsigned V_FP      = video_timing_pkg::V_FP_DEF,
   parameter int unsigned V_SYNC    = video_timing_pkg::V_SYNC_DEF,
   parameter int unsigned V_BP      = video_timing_pkg::V_BP_DEF,
   parameter logic        SYNC_POL  = 1'b0,
   parameter int unsigned LOCK_WAIT = video_timing_pkg::LOCK_WAIT_DEF,
   parameter int unsigned CNT_W     = video_timing_pkg::CNT_W_DEF
) (
   input  logic             PCLK,
   input  logic             RESET_n,
   input  logic             PLOCK,
   output logic             HSYNC,
   output logic             VSYNC,
   output logic             DE,
   output logic [CNT_W-1:0] X,
   output logic [CNT_W-1:0] Y,
   output logic             LINE_START,
   output logic             FRAME_START,
   output logic             RUN
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

   logic             run_en;
   logic [CNT_W-1:0] h_q, v_q;
   logic             hs_act, vs_act;

   lock_qualifier #(
      .LOCK_WAIT (LOCK_WAIT)
   ) u_lock (
      .PCLK    (PCLK),
      .RESET_n (RESET_n),
      .PLOCK   (PLOCK),
      .run_en  (run_en)
   );

   // Counters sit at zero outside RUN so every raster restarts at the top-left pixel.
   always_ff @(posedge PCLK) begin
      if (!RESET_n || !run_en) begin
         h_q <= '0;
         v_q <= '0;
      end else if (h_q == H_LAST) begin
         h_q <= '0;
         v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
         h_q <= h_q + 1'b1;
      end
   end

   assign hs_act = video_timing_pkg::in_window(16'(h_q), 16'(HS_START), 16'(HS_END));
   assign vs_act = video_timing_pkg::in_window(16'(v_q), 16'(VS_START), 16'(VS_END));

   always_ff @(posedge PCLK) begin
      if (!RESET_n || !run_en) begin
         HSYNC       <= ~SYNC_POL;
         VSYNC       <= ~SYNC_POL;
         DE          <= 1'b0;
         X           <= '0;
         Y           <= '0;
         LINE_START  <= 1'b0;
         FRAME_START <= 1'b0;
         RUN         <= 1'b0;
      end else begin
         HSYNC       <= hs_act ? SYNC_POL : ~SYNC_POL;
         VSYNC       <= vs_act ? SYNC_POL : ~SYNC_POL;
         DE          <= (h_q < H_ACT_C) && (v_q < V_ACT_C);
         X           <= h_q;
         Y           <= v_q;
         LINE_START  <= (h_q == '0);
         FRAME_START <= (h_q == '0) && (v_q == '0);
         RUN         <= 1'b1;
      end
   end

endmodule

// File: tb/tb_video_timing_480p.sv
// Scoreboard bench for video_timing_480p: full horizontal timing, a shortened vertical
// raster so whole frames fit in a short run, and lock/reset disturbance scenarios.
module tb_video_timing_480p;

   localparam int H_ACT = 640, H_FP = 16, H_SY = 96, H_BP = 48;
   localparam int V_ACT = 8, V_FP = 2, V_SY = 2, V_BP = 3;
   localparam int LOCK_WAIT = 16;
   localparam int CNT_W = 10;
   localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int HS_LO = H_ACT + H_FP;
   localparam int HS_HI = HS_LO + H_SY - 1;
   localparam int VS_LO = V_ACT + V_FP;
   localparam int VS_HI = VS_LO + V_SY - 1;
   localparam int RUN_LAT = LOCK_WAIT + 4;

   logic             PCLK = 1'b0;
   logic             RESET_n = 1'b0;
   logic             PLOCK = 1'b0;
   logic             HSYNC, VSYNC, DE, LINE_START, FRAME_START, RUN;
   logic [CNT_W-1:0] X, Y;

   typedef logic [25:0] rec_t;
   rec_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   t_r = 0;
   int   de_frame = 0;

   video_timing_480p #(
      .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
      .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
      .SYNC_POL (1'b0), .LOCK_WAIT (LOCK_WAIT), .CNT_W (CNT_W)
   ) dut (
      .PCLK        (PCLK),
      .RESET_n     (RESET_n),
      .PLOCK       (PLOCK),
      .HSYNC       (HSYNC),
      .VSYNC       (VSYNC),
      .DE          (DE),
      .X           (X),
      .Y           (Y),
      .LINE_START  (LINE_START),
      .FRAME_START (FRAME_START),
      .RUN         (RUN)
   );

   always #5 PCLK = ~PCLK;

   function automatic rec_t pack_obs();
      return {RUN, DE, HSYNC, VSYNC, LINE_START, FRAME_START, X, Y};
   endfunction

   function automatic rec_t idle_rec();
      return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
   endfunction

   // Expected outputs t cycles after the first (0,0) output of a raster.
   function automatic rec_t raster_rec(input int t);
      int h, v;
      h = t % H_TOT;
      v = (t / H_TOT) % V_TOT;
      return {1'b1, (h < H_ACT) && (v < V_ACT), !((h >= HS_LO) && (h <= HS_HI)),
              !((v >= VS_LO) && (v <= VS_HI)), h == 0, (h == 0) && (v == 0),
              10'(h), 10'(v)};
   endfunction

   task automatic test_reset();
      rec_t obs, want;
      RESET_n = 1'b0;
      PLOCK   = 1'b1;
      repeat (3) sb.push_back(idle_rec());
      for (int i = 1; sb.size() > 0; i++) begin
         @(negedge PCLK);
         obs = pack_obs(); want = sb.pop_front(); total++;
         if (obs !== want) begin
            bad++; $display("FAIL reset i=%0d got=%h want=%h", i, obs, want);
         end
      end
   endtask

   task automatic test_lockup();
      rec_t obs, want;
      int de_n = 0, hs_n = 0, first_run = -1, ls_prev = -1, ls_per = -1;
      RESET_n = 1'b1;
      for (int i = 0; i < RUN_LAT - 1; i++) sb.push_back(idle_rec());
      for (int t = 0; t < 2 * H_TOT; t++) sb.push_back(raster_rec(t));
      for (int i = 1; sb.size() > 0; i++) begin
         @(negedge PCLK);
         obs = pack_obs(); want = sb.pop_front(); total++;
         if (obs !== want) begin
            bad++; $display("FAIL lockup i=%0d got=%h want=%h", i, obs, want);
         end
         if (RUN === 1'b1 && first_run < 0) first_run = i;
         if (DE === 1'b1) de_n++;
         if (HSYNC === 1'b0) hs_n++;
         if (LINE_START === 1'b1) begin
            if (ls_prev >= 0) ls_per = i - ls_prev;
            ls_prev = i;
         end
      end
      total++;
      if (first_run !== RUN_LAT) begin
         bad++; $display("FAIL run_rise got=%0d want=%0d", first_run, RUN_LAT);
      end
      total++;
      if (de_n !== 2 * H_ACT) begin
         bad++; $display("FAIL de_per_2lines got=%0d want=%0d", de_n, 2 * H_ACT);
      end
      total++;
      if (hs_n !== 2 * H_SY) begin
         bad++; $display("FAIL hsync_low_2lines got=%0d want=%0d", hs_n, 2 * H_SY);
      end
      total++;
      if (ls_per !== H_TOT) begin
         bad++; $display("FAIL line_period got=%0d want=%0d", ls_per, H_TOT);
      end
      de_frame = de_n;
      t_r = 2 * H_TOT - 1;
   endtask

   task automatic test_frame();
      rec_t obs, want;
      int t_end = FRAME + H_TOT - 1;
      int vs_n = 0, fs_t = -1, fs_n = 0, y_max = 0;
      for (int t = t_r + 1; t <= t_end; t++) sb.push_back(raster_rec(t));
      for (int t = t_r + 1; sb.size() > 0; t++) begin
         @(negedge PCLK);
         obs = pack_obs(); want = sb.pop_front(); total++;
         if (obs !== want) begin
            bad++; $display("FAIL frame t=%0d got=%h want=%h", t, obs, want);
         end
         if (t < FRAME) begin
            if (DE === 1'b1) de_frame++;
            if (VSYNC === 1'b0) vs_n++;
         end
         if (FRAME_START === 1'b1) begin
            fs_t = t; fs_n++;
         end
         if (int'(Y) > y_max) y_max = int'(Y);
      end
      total++;
      if (de_frame !== V_ACT * H_ACT) begin
         bad++; $display("FAIL de_per_frame got=%0d want=%0d", de_frame, V_ACT * H_ACT);
      end
      total++;
      if (vs_n !== V_SY * H_TOT) begin
         bad++; $display("FAIL vsync_low got=%0d want=%0d", vs_n, V_SY * H_TOT);
      end
      total++;
      if (fs_t !== FRAME || fs_n !== 1) begin
         bad++; $display("FAIL frame_period got=%0d n=%0d want=%0d", fs_t, fs_n, FRAME);
      end
      total++;
      if (y_max !== V_TOT - 1) begin
         bad++; $display("FAIL y_max got=%0d want=%0d", y_max, V_TOT - 1);
      end
      t_r = t_end;
   endtask

   task automatic test_lock_loss();
      rec_t obs, want;
      int loss_l = 5;
      int t_loss = FRAME + 3 * H_TOT + 100;
      int n_pre = t_loss - t_r;
      int first_idle = -1;
      for (int t = t_r + 1; t <= t_loss + 2; t++) sb.push_back(raster_rec(t));
      for (int i = 0; i < loss_l + 17; i++) sb.push_back(idle_rec());
      for (int t = 0; t < H_TOT; t++) sb.push_back(raster_rec(t));
      for (int i = 1; sb.size() > 0; i++) begin
         @(negedge PCLK);
         obs = pack_obs(); want = sb.pop_front(); total++;
         if (obs !== want) begin
            bad++; $display("FAIL lockloss i=%0d got=%h want=%h", i, obs, want);
         end
         if (i > n_pre && first_idle < 0 && RUN === 1'b0) first_idle = i - n_pre;
         if (i == n_pre) PLOCK = 1'b0;
         if (i == n_pre + loss_l) PLOCK = 1'b1;
      end
      total++;
      if (first_idle !== 3) begin
         bad++; $display("FAIL lockloss_latency got=%0d want=3", first_idle);
      end
      t_r = H_TOT - 1;
   endtask

   task automatic test_reset_midframe();
      rec_t obs, want;
      int t_rst = 5 * H_TOT + 300;
      int n_pre = t_rst - t_r;
      int back = -1;
      for (int t = t_r + 1; t <= t_rst; t++) sb.push_back(raster_rec(t));
      for (int i = 0; i < RUN_LAT; i++) sb.push_back(idle_rec());
      for (int t = 0; t < H_TOT; t++) sb.push_back(raster_rec(t));
      for (int i = 1; sb.size() > 0; i++) begin
         @(negedge PCLK);
         obs = pack_obs(); want = sb.pop_front(); total++;
         if (obs !== want) begin
            bad++; $display("FAIL reset_mid i=%0d got=%h want=%h", i, obs, want);
         end
         if (i > n_pre + 1 && back < 0 && RUN === 1'b1) back = i - n_pre;
         if (i == n_pre) RESET_n = 1'b0;
         if (i == n_pre + 1) RESET_n = 1'b1;
      end
      total++;
      if (back !== RUN_LAT + 1) begin
         bad++; $display("FAIL reset_mid_rerun got=%0d want=%0d", back, RUN_LAT + 1);
      end
      t_r = H_TOT - 1;
   endtask

   task automatic test_settle_glitch();
      rec_t obs, want;
      int gl_drop = 11, gl_len = 3;
      int first_run = -1;
      RESET_n = 1'b0;
      PLOCK   = 1'b0;
      repeat (2) sb.push_back(idle_rec());
      for (int i = 1; sb.size() > 0; i++) begin
         @(negedge PCLK);
         obs = pack_obs(); want = sb.pop_front(); total++;
         if (obs !== want) begin
            bad++; $display("FAIL glitch_rst i=%0d got=%h want=%h", i, obs, want);
         end
      end
      RESET_n = 1'b1;
      PLOCK   = 1'b1;
      for (int i = 0; i < gl_drop + gl_len + LOCK_WAIT + 3; i++) sb.push_back(idle_rec());
      for (int t = 0; t < 50; t++) sb.push_back(raster_rec(t));
      for (int i = 1; sb.size() > 0; i++) begin
         @(negedge PCLK);
         obs = pack_obs(); want = sb.pop_front(); total++;
         if (obs !== want) begin
            bad++; $display("FAIL glitch i=%0d got=%h want=%h", i, obs, want);
         end
         if (first_run < 0 && RUN === 1'b1) first_run = i;
         if (i == gl_drop) PLOCK = 1'b0;
         if (i == gl_drop + gl_len) PLOCK = 1'b1;
      end
      total++;
      if (first_run !== gl_drop + gl_len + LOCK_WAIT + 4) begin
         bad++; $display("FAIL glitch_rerun got=%0d want=%0d", first_run,
                         gl_drop + gl_len + LOCK_WAIT + 4);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lockup();
      test_frame();
      test_lock_loss();
      test_reset_midframe();
      test_settle_glitch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
